// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
// Round-robin arbiter that shares a single I2C write engine between NUM_REQ
// requesters. The winner's device address, data address and write byte are
// latched and presented to the engine, a one-cycle start pulse is issued,
// and the arbiter waits for the engine's completion flag before sending a
// one-cycle acknowledge back to the winner.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   defined   : WAIT aborts after TIMEOUT_CYC cycles without completion and
//               pulses o_err together with o_ack for the owner.
//   undefined : WAIT waits indefinitely, o_err is constant 0.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req            per-requester request level
//   i_device_addr    packed 7-bit device addresses, requester k at [7k+6:7k]
//   i_data_addr      packed 8-bit data addresses,   requester k at [8k+7:8k]
//   i_write_data     packed 8-bit write bytes,      requester k at [8k+7:8k]
//   o_grant          one-hot owner of the current transaction (0 when idle)
//   o_ack            one-cycle completion pulse to the owner
//   o_err            one-cycle timeout pulse to the owner (with o_ack)
//   o_busy           high whenever the arbiter is not idle
//   o_i2c_en         one-cycle start pulse to the engine
//   o_device_addr    latched device address to the engine
//   o_data_addr      latched data address to the engine
//   o_write_data     latched write byte to the engine
//   i_done_flag      completion flag from the engine
// ---------------------------------------------------------------------------
module i2c_master_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [7*NUM_REQ-1:0] i_device_addr,
    input  logic [8*NUM_REQ-1:0] i_data_addr,
    input  logic [8*NUM_REQ-1:0] i_write_data,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [NUM_REQ-1:0]   o_err,
    output logic                 o_busy,
    output logic                 o_i2c_en,
    output logic [6:0]           o_device_addr,
    output logic [7:0]           o_data_addr,
    output logic [7:0]           o_write_data,
    input  logic                 i_done_flag
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DEV_W  = 7;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 en_q, en_d;
    logic [DEV_W-1:0]     dev_q, dev_d;
    logic [BYTE_W-1:0]    daddr_q, daddr_d;
    logic [BYTE_W-1:0]    wdata_q, wdata_d;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
`endif

    // Round-robin search starting one past the last served requester
    logic                 found;
    logic [IDX_W-1:0]     pick;

    always_comb begin : rr_pick
        found = 1'b0;
        pick  = last_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!found && i_req[IDX_W'((32'(last_q) + i) % NUM_REQ)]) begin
                found = 1'b1;
                pick  = IDX_W'((32'(last_q) + i) % NUM_REQ);
            end
        end
    end

    // Select the picked requester's fields from the packed buses
    logic [DEV_W-1:0]     dev_sel;
    logic [BYTE_W-1:0]    daddr_sel;
    logic [BYTE_W-1:0]    wdata_sel;

    always_comb begin : field_mux
        dev_sel   = '0;
        daddr_sel = '0;
        wdata_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                dev_sel   = i_device_addr[DEV_W*k +: DEV_W];
                daddr_sel = i_data_addr[BYTE_W*k +: BYTE_W];
                wdata_sel = i_write_data[BYTE_W*k +: BYTE_W];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            win_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            dev_q   <= '0;
            daddr_q <= '0;
            wdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            dev_q   <= dev_d;
            daddr_q <= daddr_d;
            wdata_q <= wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin : fsm_next
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        grant_d = grant_q;
        ack_d   = '0;
        busy_d  = busy_q;
        en_d    = 1'b0;
        dev_d   = dev_q;
        daddr_d = daddr_q;
        wdata_d = wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    dev_d   = dev_sel;
                    daddr_d = daddr_sel;
                    wdata_d = wdata_sel;
                    busy_d  = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                en_d    = 1'b1;
                state_d = ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end

            ST_WAIT: begin
                // Completion wins over a coincident terminal count
                if (i_done_flag) begin
                    ack_d   = grant_q;
                    last_d  = win_q;
                    state_d = ST_DONE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LIMIT) begin
                    ack_d   = grant_q;
                    err_d   = grant_q;
                    last_d  = win_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_grant       = grant_q;
    assign o_ack         = ack_q;
    assign o_busy        = busy_q;
    assign o_i2c_en      = en_q;
    assign o_device_addr = dev_q;
    assign o_data_addr   = daddr_q;
    assign o_write_data  = wdata_q;

`ifdef I2C_ARB_TIMEOUT_EN
    assign o_err = err_q;
`else
    assign o_err = '0;

    // Timeout limit only matters when the abort path is built
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule
